// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed byte image (count, LE words, XOR
// checksum) over valid/ready, writes each word to the imem write port and holds the core.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DepthW = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {StInit, StHdr0, StHdr1, StData, StChk, StDone, StErr} state_e;

  state_e              r_state, w_state_d;
  logic [7:0]          r_xor;
  logic [15:0]         r_n;
  logic [1:0]          r_lane;
  logic [ADDR_W:0]     r_k;
  logic [23:0]         r_asm;
  logic                r_rx_ready, r_im_we, r_core_hold, r_done, r_err;
  logic [ADDR_W-1:0]   r_im_waddr;
  logic [31:0]         r_im_wdata;

  logic                w_acc;
  logic [15:0]         w_n_hdr;
  logic [ADDR_W:0]     w_k_inc;
  logic                w_last_word;
  logic                w_oversize;
  logic                w_rx_ready_d, w_im_we_d, w_core_hold_d, w_done_d, w_err_d;

  assign w_acc       = rx_valid & r_rx_ready;
  assign w_n_hdr     = {rx_data, r_n[7:0]};
  assign w_k_inc     = r_k + 1'b1;
  assign w_last_word = ({{(15 - ADDR_W){1'b0}}, w_k_inc} == r_n);
  assign w_oversize  = ({1'b0, w_n_hdr} > DepthW);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit: w_state_d = StHdr0;
      StHdr0: if (w_acc) w_state_d = StHdr1;
      StHdr1: begin
        if (w_acc) begin
          if (w_oversize)            w_state_d = StErr;
          else if (w_n_hdr == 16'd0) w_state_d = StChk;
          else                       w_state_d = StData;
        end
      end
      StData: if (w_acc && (r_lane == 2'd3) && w_last_word) w_state_d = StChk;
      StChk:  if (w_acc) w_state_d = (rx_data == r_xor) ? StDone : StErr;
      default: w_state_d = r_state;
    endcase
  end

  // Output logic, decoded from the next state so the registered outputs track the state
  always_comb begin
    w_rx_ready_d  = (w_state_d == StHdr0) || (w_state_d == StHdr1) ||
                    (w_state_d == StData) || (w_state_d == StChk);
    w_done_d      = (w_state_d == StDone);
    w_err_d       = (w_state_d == StErr);
    w_core_hold_d = (w_state_d != StDone);
    w_im_we_d     = (r_state == StData) && w_acc && (r_lane == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ready  <= 1'b0;
      r_im_we     <= 1'b0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rx_ready  <= w_rx_ready_d;
      r_im_we     <= w_im_we_d;
      r_core_hold <= w_core_hold_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
    end
  end

  // Datapath: header capture, running XOR, word assembly and write address/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor      <= 8'd0;
      r_n        <= 16'd0;
      r_lane     <= 2'd0;
      r_k        <= '0;
      r_asm      <= 24'd0;
      r_im_waddr <= '0;
      r_im_wdata <= 32'd0;
    end else if (w_acc) begin
      case (r_state)
        StHdr0: begin
          r_n[7:0] <= rx_data;
          r_xor    <= r_xor ^ rx_data;
        end
        StHdr1: begin
          r_n[15:8] <= rx_data;
          r_xor     <= r_xor ^ rx_data;
        end
        StData: begin
          r_xor  <= r_xor ^ rx_data;
          r_lane <= r_lane + 2'd1;
          if (r_lane == 2'd3) begin
            r_im_wdata <= {rx_data, r_asm};
            r_im_waddr <= r_k[ADDR_W-1:0];
            r_k        <= w_k_inc;
            r_asm      <= 24'd0;
          end else begin
            r_asm[{r_lane, 3'b000} +: 8] <= rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready  = r_rx_ready;
  assign im_we     = r_im_we;
  assign im_waddr  = r_im_waddr;
  assign im_wdata  = r_im_wdata;
  assign core_hold = r_core_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed frame table, hand-written reset/oversize/full-depth
// sequences and random frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int          Depth  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_ready, im_we, core_hold, done, err;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  bit                exp_done, exp_err;
  logic [7:0]        tx_q[$];

  typedef struct {
    int          len;
    logic [7:0]  b [12];
    int          stall;
    bit          e_done;
    bit          e_err;
    int          e_nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t tbl [7];

  // Every im_we cycle is one write; a stuck strobe shows up as extra entries
  always @(negedge clk) begin
    if (!rst && im_we) begin
      got_addr.push_back(im_waddr);
      got_data.push_back(im_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " rx_ready"},  32'(rx_ready),  32'd0);
    chk({tag, " im_we"},     32'(im_we),     32'd0);
    chk({tag, " im_waddr"},  32'(im_waddr),  32'd0);
    chk({tag, " im_wdata"},  im_wdata,       32'd0);
    chk({tag, " core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " err"},       32'(err),       32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
    #1;
    chk("init rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("hdr0 rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Offers tx_q byte by byte; returns at the negedge right after the last acceptance edge
  task automatic send_frame(input int stall);
    int  budget;
    bit  acc;
    logic rdy;
    for (int i = 0; i < tx_q.size(); i++) begin
      budget = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        if (int'($urandom_range(99)) < stall) begin
          rx_valid = 1'b0;
        end else begin
          rx_valid = 1'b1;
          rx_data  = tx_q[i];
        end
        rdy = rx_ready;
        @(posedge clk);
        acc = rx_valid && rdy;
        budget++;
        if (!acc && budget > 500) begin
          checks++;
          errors++;
          $display("FAIL accept byte %0d: not accepted within %0d cycles", i, budget);
          @(negedge clk);
          rx_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Frame-level reference: decode count, words and checksum directly from the byte list
  task automatic model();
    int         n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'({tx_q[1], tx_q[0]});
    if (n > Depth) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= tx_q[i];
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(ADDR_W'(w));
      exp_data.push_back({tx_q[2+4*w+3], tx_q[2+4*w+2], tx_q[2+4*w+1], tx_q[2+4*w]});
    end
    exp_done = (tx_q[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  task automatic check_outcome(input string tag);
    int nw;
    chk({tag, " done"},      32'(done),      32'(exp_done));
    chk({tag, " err"},       32'(err),       32'(exp_err));
    chk({tag, " core_hold"}, 32'(core_hold), 32'(!exp_done));
    chk({tag, " rx_ready"},  32'(rx_ready),  32'd0);
    chk({tag, " nwrites"},   32'(got_addr.size()), 32'(exp_addr.size()));
    nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s waddr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("%s wdata[%0d]", tag, i), got_data[i], exp_data[i]);
    end
    repeat (3) @(negedge clk);
    chk({tag, " sticky done"}, 32'(done), 32'(exp_done));
    chk({tag, " sticky err"},  32'(err),  32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] x;
    int         n, stall, seen;

    tbl[0] = '{len: 11, b: '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h33, 8'h00}, stall: 0, e_done: 1, e_err: 0, e_nw: 2, w0: 32'h13, w1: 32'hDEADBEEF};
    tbl[1] = '{len: 11, b: '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h34, 8'h00}, stall: 0, e_done: 0, e_err: 1, e_nw: 2, w0: 32'h13, w1: 32'hDEADBEEF};
    tbl[2] = '{len: 2, b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, stall: 0, e_done: 0, e_err: 1, e_nw: 0, w0: 32'h0, w1: 32'h0};
    tbl[3] = '{len: 3, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, stall: 0, e_done: 1, e_err: 0, e_nw: 0, w0: 32'h0, w1: 32'h0};
    tbl[4] = '{len: 11, b: '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h33, 8'h00}, stall: 50, e_done: 1, e_err: 0, e_nw: 2, w0: 32'h13, w1: 32'hDEADBEEF};
    tbl[5] = '{len: 7, b: '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, stall: 0, e_done: 1, e_err: 0, e_nw: 1, w0: 32'h12345678, w1: 32'h0};
    tbl[6] = '{len: 3, b: '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, stall: 0, e_done: 0, e_err: 1, e_nw: 0, w0: 32'h0, w1: 32'h0};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      tx_q.delete();
      for (int j = 0; j < tbl[i].len; j++) tx_q.push_back(tbl[i].b[j]);
      exp_done = tbl[i].e_done;
      exp_err  = tbl[i].e_err;
      exp_addr.delete();
      exp_data.delete();
      if (tbl[i].e_nw > 0) begin exp_addr.push_back(0); exp_data.push_back(tbl[i].w0); end
      if (tbl[i].e_nw > 1) begin exp_addr.push_back(1); exp_data.push_back(tbl[i].w1); end
      send_frame(tbl[i].stall);
      check_outcome($sformatf("vec%0d", i));
    end

    // Oversize: no further byte may be consumed after rejection
    do_reset();
    tx_q = '{8'h01, 8'h01};
    send_frame(0);
    chk("oversize err", 32'(err), 32'd1);
    seen = 0;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      if (rx_ready) seen++;
    end
    rx_valid = 1'b0;
    chk("oversize ready cycles", 32'(seen), 32'd0);
    chk("oversize nwrites", 32'(got_addr.size()), 32'd0);

    // Reset mid-load after 5 data bytes, then a clean reload
    do_reset();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF};
    send_frame(0);
    chk("midload wdata before rst", im_wdata, 32'h13);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midreset");
    do_reset();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    model();
    send_frame(0);
    check_outcome("reload");

    // Full-depth image: N == DEPTH
    do_reset();
    tx_q.delete();
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    x = 8'h01;
    for (int i = 0; i < 4 * Depth; i++) begin
      tx_q.push_back(8'($urandom));
      x ^= tx_q[tx_q.size() - 1];
    end
    tx_q.push_back(x);
    model();
    send_frame(0);
    check_outcome("fulldepth");

    // Random frames with random stalls, some oversize, some with corrupted checksum
    for (int it = 0; it < 12; it++) begin
      do_reset();
      tx_q.delete();
      n = (it % 4 == 3) ? int'($urandom_range(65535, Depth + 1)) : int'($urandom_range(5, 0));
      stall = int'($urandom_range(60, 0));
      tx_q.push_back(n[7:0]);
      tx_q.push_back(n[15:8]);
      x = n[7:0] ^ n[15:8];
      if (n <= Depth) begin
        for (int i = 0; i < 4 * n; i++) begin
          tx_q.push_back(8'($urandom));
          x ^= tx_q[tx_q.size() - 1];
        end
        if ($urandom_range(1) == 1) x ^= 8'(1 << $urandom_range(7));
        tx_q.push_back(x);
      end
      model();
      send_frame(stall);
      check_outcome($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
